// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and state constants for the instruction-fetch stage
package fetch_unit_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {PC_SEQ = 2'b00, PC_JR = 2'b01, PC_J = 2'b10, PC_BR = 2'b11} pcsrc_t;
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FETCH  = 2'd0;
  localparam fetch_state_t HOLD   = 2'd1;
  localparam fetch_state_t HALTED = 2'd2;
endpackage

// File: rtl/fetch_unit_target.sv
// pc_target_calc: combinational redirect target selection for JR, J/JAL and taken branch
module pc_target_calc
  import fetch_unit_pkg::*;
(
  input  pcsrc_t      i_src,
  input  word_t       i_npc,
  input  word_t       i_jr,
  input  logic [25:0] i_j,
  input  logic [15:0] i_imm,
  output word_t       o_target
);
  always_comb
    o_target = (i_src == PC_JR) ? {i_jr[31:2], 2'b00} :
               (i_src == PC_J)  ? {i_npc[31:28], i_j, 2'b00} :
                                  i_npc + {{14{i_imm[15]}}, i_imm, 2'b00};
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues single-outstanding I-cache reads and holds the fetched word for decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  word_t       imemload,
  output logic        imemREN,
  output word_t       imemaddr,
  output word_t       instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output word_t       instr_pc,
  output word_t       instr_npc,
  input  logic        redirect,
  input  logic [1:0]  pc_src,
  input  word_t       redir_npc,
  input  word_t       jr_target,
  input  logic [25:0] j_addr,
  input  logic [15:0] br_imm16,
  input  logic        halt,
  output logic        halted
);
  fetch_state_t r_state;
  word_t        r_pc, r_instr, r_ipc, r_npc, w_target;
  logic         r_valid, w_redir, w_free;
  pc_target_calc u_target (
    .i_src   (pcsrc_t'(pc_src)),
    .i_npc   (redir_npc),
    .i_jr    (jr_target),
    .i_j     (j_addr),
    .i_imm   (br_imm16),
    .o_target(w_target)
  );
  assign w_redir     = redirect && (pc_src != 2'b00);
  assign w_free      = !r_valid || instr_ready;
  assign imemREN     = (r_state == FETCH);
  assign imemaddr    = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign instr_pc    = r_ipc;
  assign instr_npc   = r_npc;
  assign halted      = (r_state == HALTED);
  // halt outranks redirect, which outranks any same-cycle hit or handshake
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= FETCH;
      r_pc    <= PC_INIT;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ipc   <= '0;
      r_npc   <= '0;
    end else if (halt) begin
      r_state <= HALTED;
      r_valid <= 1'b0;
    end else if (r_state != HALTED) begin
      if (w_redir) begin
        r_pc    <= w_target;
        r_valid <= 1'b0;
        r_state <= FETCH;
      end else if (r_state == HOLD) begin
        if (instr_ready) begin
          r_valid <= 1'b0;
          r_state <= FETCH;
        end
      end else if (ihit && w_free) begin
        r_instr <= imemload;
        r_ipc   <= r_pc;
        r_npc   <= r_pc + 32'd4;
        r_valid <= 1'b1;
        r_pc    <= r_pc + 32'd4;
      end else if (ihit) begin
        r_state <= HOLD;
      end else if (instr_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic checked against a behavioural fetch model
module tb_fetch_unit;
  logic        clk = 1'b0, rst = 1'b1, ihit = 1'b0, instr_ready = 1'b0, redirect = 1'b0, halt = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] redir_npc = '0, jr_target = '0, imemload;
  logic [25:0] j_addr = '0;
  logic [15:0] br_imm16 = '0;
  logic        imemREN, instr_valid, halted;
  logic [31:0] imemaddr, instr, instr_pc, instr_npc;
  int          total = 0, bad = 0;
  logic [31:0] m_pc, m_instr, m_ipc, m_npc, saved;
  bit          m_valid, m_hold, m_halted, m_known = 1'b0;

  fetch_unit dut (
    .CLK(clk), .RST(rst), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
    .imemaddr(imemaddr), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_pc(instr_pc), .instr_npc(instr_npc), .redirect(redirect), .pc_src(pc_src),
    .redir_npc(redir_npc), .jr_target(jr_target), .j_addr(j_addr), .br_imm16(br_imm16),
    .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign imemload = memw(imemaddr);

  function automatic logic [31:0] target(input logic [1:0] s);
    int signed off;
    off = int'($signed(br_imm16)) * 4;
    if (s == 2'b01) return jr_target & 32'hFFFF_FFFC;
    if (s == 2'b10) return (redir_npc & 32'hF000_0000) | (32'(j_addr) * 4);
    return redir_npc + 32'(off);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit h, input bit rd, input bit rdr,
                     input logic [1:0] src, input bit hl);
    rst = r; ihit = h; instr_ready = rd; redirect = rdr; pc_src = src; halt = hl;
    if (m_known) begin
      chk("ren", 32'(imemREN), 32'(!m_halted && !m_hold));
      chk("addr", imemaddr, m_pc);
      chk("valid", 32'(instr_valid), 32'(m_valid));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("instr", instr, m_instr);
      chk("ipc", instr_pc, m_ipc);
      chk("npc", instr_npc, m_npc);
    end
    if (r) begin
      m_pc = 0; m_instr = 0; m_ipc = 0; m_npc = 0;
      m_valid = 0; m_hold = 0; m_halted = 0; m_known = 1;
    end else if (hl) begin
      m_halted = 1; m_valid = 0;
    end else if (!m_halted) begin
      if (rdr && src != 2'b00) begin
        m_pc = target(src); m_valid = 0; m_hold = 0;
      end else if (m_hold) begin
        if (rd) begin m_valid = 0; m_hold = 0; end
      end else if (h && (!m_valid || rd)) begin
        m_instr = memw(m_pc); m_ipc = m_pc; m_npc = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      end else if (h) begin
        m_hold = 1;
      end else if (rd) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 2'b00, 0);
    cyc(1, 0, 0, 0, 2'b00, 0);
    chk("t1_reset_addr", imemaddr, 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 2'b00, 0);
    chk("t1_addr", imemaddr, 32'h10);
    chk("t1_ipc", instr_pc, 32'hC);
    cyc(0, 1, 0, 0, 2'b00, 0);
    chk("t2_ren", 32'(imemREN), 32'h0);
    chk("t2_held_pc", instr_pc, 32'hC);
    cyc(0, 0, 1, 0, 2'b00, 0);
    chk("t2_refetch", imemaddr, 32'h10);
    cyc(0, 1, 1, 0, 2'b00, 0);
    chk("t2_next_pc", instr_pc, 32'h10);
    redir_npc = 32'h100; br_imm16 = 16'hFFFE;
    cyc(0, 1, 1, 1, 2'b11, 0);
    chk("t3_br_addr", imemaddr, 32'hF8);
    chk("t3_valid", 32'(instr_valid), 32'h0);
    redir_npc = 32'hA000_0010; j_addr = 26'h10;
    cyc(0, 1, 1, 1, 2'b10, 0);
    chk("t4_j_addr", imemaddr, 32'hA000_0040);
    jr_target = 32'h203;
    cyc(0, 0, 1, 1, 2'b01, 0);
    chk("t4_jr_addr", imemaddr, 32'h200);
    cyc(0, 1, 1, 1, 2'b00, 0);
    chk("t4_seq_addr", imemaddr, 32'h204);
    jr_target = 32'hFFFF_FFFF;
    cyc(0, 0, 1, 1, 2'b01, 0);
    cyc(0, 1, 1, 0, 2'b00, 0);
    chk("wrap_addr", imemaddr, 32'h0);
    chk("wrap_npc", instr_npc, 32'h0);
    saved = imemaddr; jr_target = 32'h300;
    cyc(0, 1, 1, 1, 2'b01, 1);
    chk("t5_halted", 32'(halted), 32'h1);
    chk("t5_pc", imemaddr, saved);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 2'b01, 0);
    chk("t5_ren", 32'(imemREN), 32'h0);
    cyc(1, 0, 0, 0, 2'b00, 0);
    chk("t5_unhalt", 32'(halted), 32'h0);
    chk("t5_init", imemaddr, 32'h0);
    cyc(0, 1, 1, 0, 2'b00, 0);
    cyc(0, 0, 1, 0, 2'b00, 0);
    cyc(0, 0, 0, 0, 2'b00, 0);
    cyc(1, 1, 1, 0, 2'b00, 0);
    chk("t6_valid", 32'(instr_valid), 32'h0);
    chk("t6_addr", imemaddr, 32'h0);
    chk("t6_instr", instr, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      redir_npc = $urandom; jr_target = $urandom; j_addr = 26'($urandom); br_imm16 = 16'($urandom);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
          $urandom_range(0, 9) == 0, 2'($urandom), $urandom_range(0, 149) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
